// File: rtl/serial_link_if.sv
// ---------------------------------------------------------------------------
// serial_link_if
//   CPU-side I/O bus between the MMU chip-select logic and the serial port
//   controller (SB at 0xFF01, SC at 0xFF02).
//
//   Signals:
//     cs    - chip select for the 0xFF01..0xFF02 window
//     rd_n  - active-low read strobe
//     wr_n  - active-low write strobe
//     A     - 16-bit CPU address
//     Di    - CPU write data
//     Do    - read data returned by the serial port
//
//   Modports:
//     master - the MMU / CPU side (drives strobes, address and write data)
//     slave  - the serial port (returns read data)
// ---------------------------------------------------------------------------
interface serial_link_if;
    logic        cs;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] A;
    logic [7:0]  Di;
    logic [7:0]  Do;

    modport master (
        output cs,
        output rd_n,
        output wr_n,
        output A,
        output Di,
        input  Do
    );

    modport slave (
        input  cs,
        input  rd_n,
        input  wr_n,
        input  A,
        input  Di,
        output Do
    );
endinterface

// File: rtl/serial_link.sv
// ---------------------------------------------------------------------------
// serial_link
//   Game Boy serial port controller implementing SB (0xFF01) and SC (0xFF02).
//   One byte is shifted out on sout (MSB first) while one byte is shifted in
//   from sin, clocked either by an internal divider or by an external serial
//   clock. Completion raises int_req, which holds until int_ack.
//
//   Parameters:
//     CLK_DIV  - system clocks per internal serial bit period (even, >= 64)
//
//   Ports:
//     clock     - system clock, rising-edge active
//     reset     - asynchronous, active-high reset
//     bus       - CPU I/O bus (serial_link_if.slave): cs, rd_n, wr_n, A, Di, Do
//     int_req   - serial interrupt request
//     int_ack   - interrupt acknowledge, clears int_req
//     sclk_in   - external serial clock (asynchronous)
//     sclk_out  - serial clock driven in internal-clock mode
//     sclk_oe   - high when sclk_out drives the link
//     sin       - serial data in (asynchronous)
//     sout      - serial data out
//
//   Optional feature macro: SERIAL_FAST_CLOCK_EN
//     When defined, SC bit1 (fast) is stored and shortens the internal bit
//     period to CLK_DIV/32. When undefined, bit1 is not stored and reads 1.
// ---------------------------------------------------------------------------
module serial_link #(
    parameter int CLK_DIV = 512
) (
    input  logic         clock,
    input  logic         reset,
    serial_link_if.slave bus,
    output logic         int_req,
    input  logic         int_ack,
    input  logic         sclk_in,
    output logic         sclk_out,
    output logic         sclk_oe,
    input  logic         sin,
    output logic         sout
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_HALF = DIV_W'(CLK_DIV / 2);
`ifdef SERIAL_FAST_CLOCK_EN
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(CLK_DIV / 32 - 1);
    localparam logic [DIV_W-1:0] FAST_HALF = DIV_W'(CLK_DIV / 64);
`endif

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       sb;
    logic             start;
    logic             clk_sel;
`ifdef SERIAL_FAST_CLOCK_EN
    logic             fast;
`endif
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] divider;

    logic sclk_s1;
    logic sclk_s2;
    logic sclk_prev;
    logic sin_s1;
    logic sin_s2;

    logic             wr_sb;
    logic             wr_sc;
    logic             rd_en;
    logic [7:0]       sc_value;
    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W-1:0] half_cnt;
    logic [DIV_W-1:0] div_next;
    logic             int_rise;
    logic             int_wrap;
    logic [3:0]       bits_after;
    logic [7:0]       sb_shift;
    logic             ext_rise;
    logic             ext_fall;

`ifdef SERIAL_FAST_CLOCK_EN
    logic unused_di;
    assign unused_di = ^bus.Di[6:2];
`else
    logic unused_di;
    assign unused_di = ^bus.Di[6:1];
`endif

    assign wr_sb = bus.cs && !bus.wr_n && (bus.A == 16'hFF01);
    assign wr_sc = bus.cs && !bus.wr_n && (bus.A == 16'hFF02);
    assign rd_en = bus.cs && !bus.rd_n;

    assign sclk_oe = clk_sel;

`ifdef SERIAL_FAST_CLOCK_EN
    assign sc_value = {start, 5'b11111, fast, clk_sel};
`else
    assign sc_value = {start, 6'b111111, clk_sel};
`endif

    // Read data is purely combinational; anything outside the two registers
    // (or no active read) floats the bus high.
    always_comb begin
        bus.Do = 8'hFF;
        if (rd_en) begin
            if (bus.A == 16'hFF01) begin
                bus.Do = sb;
            end else if (bus.A == 16'hFF02) begin
                bus.Do = sc_value;
            end
        end
    end

    // Internal bit period: the low half of the divider drives sclk_out low,
    // the high half drives it high.
    always_comb begin
        last_cnt = SLOW_LAST;
        half_cnt = SLOW_HALF;
`ifdef SERIAL_FAST_CLOCK_EN
        if (fast) begin
            last_cnt = FAST_LAST;
            half_cnt = FAST_HALF;
        end
`endif
    end

    // The shift and the falling-edge sout update can coincide on very short
    // periods, so the post-shift byte and bit count are computed up front.
    assign div_next   = (divider == last_cnt) ? '0 : divider + 1'b1;
    assign int_rise   = (divider == half_cnt);
    assign int_wrap   = (divider == last_cnt);
    assign bits_after = bit_cnt + {3'b000, int_rise};
    assign sb_shift   = {sb[6:0], sin_s2};
    assign ext_rise   = sclk_s2 && !sclk_prev;
    assign ext_fall   = !sclk_s2 && sclk_prev;

    // Main controller. Synchronisers run every cycle; an SC write always wins
    // over transfer progress (it either restarts or aborts). In internal mode
    // the transfer finishes at the end of the 8th bit period so the partner
    // sees a complete final clock high phase; in external mode it finishes on
    // the 8th synchronised rising edge. Completion has priority over int_ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sb        <= 8'h00;
            start     <= 1'b0;
            clk_sel   <= 1'b0;
`ifdef SERIAL_FAST_CLOCK_EN
            fast      <= 1'b0;
`endif
            int_req   <= 1'b0;
            bit_cnt   <= 4'd0;
            divider   <= '0;
            sout      <= 1'b1;
            sclk_out  <= 1'b1;
            sclk_s1   <= 1'b1;
            sclk_s2   <= 1'b1;
            sclk_prev <= 1'b1;
            sin_s1    <= 1'b1;
            sin_s2    <= 1'b1;
        end else begin
            sclk_s1   <= sclk_in;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            sin_s1    <= sin;
            sin_s2    <= sin_s1;

            if (int_ack) begin
                int_req <= 1'b0;
            end

            if (wr_sb && (state != XFER)) begin
                sb <= bus.Di;
            end

            if (wr_sc) begin
                start   <= bus.Di[7];
                clk_sel <= bus.Di[0];
`ifdef SERIAL_FAST_CLOCK_EN
                fast    <= bus.Di[1];
`endif
                bit_cnt <= 4'd0;
                divider <= '0;
                if (bus.Di[7]) begin
                    state    <= XFER;
                    sout     <= sb[7];
                    sclk_out <= !bus.Di[0];
                end else begin
                    state    <= IDLE;
                    sout     <= 1'b1;
                    sclk_out <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                    end
                    XFER: begin
                        if (clk_sel) begin
                            divider  <= div_next;
                            sclk_out <= (div_next >= half_cnt);
                            if (int_rise) begin
                                sb      <= sb_shift;
                                bit_cnt <= bits_after;
                            end
                            if (int_wrap) begin
                                if (bits_after == 4'd8) begin
                                    state    <= DONE;
                                    start    <= 1'b0;
                                    int_req  <= 1'b1;
                                    bit_cnt  <= 4'd0;
                                    divider  <= '0;
                                    sout     <= 1'b1;
                                    sclk_out <= 1'b1;
                                end else begin
                                    sout <= int_rise ? sb_shift[7] : sb[7];
                                end
                            end
                        end else begin
                            if (ext_fall) begin
                                sout <= sb[7];
                            end
                            if (ext_rise) begin
                                sb <= sb_shift;
                                if (bit_cnt == 4'd7) begin
                                    state    <= DONE;
                                    start    <= 1'b0;
                                    int_req  <= 1'b1;
                                    bit_cnt  <= 4'd0;
                                    divider  <= '0;
                                    sout     <= 1'b1;
                                    sclk_out <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_link.sv
// ---------------------------------------------------------------------------
// tb_serial_link
//   Randomised self-checking bench for serial_link. Register reads and the
//   bits seen on sout at each internal sclk_out rising edge are checked by
//   monitor processes against expectations queued by the stimulus. Expected
//   values come from a byte-level model: a transfer sends SB MSB first and
//   leaves the received byte in SB; SC reads back start/fast/clk_sel.
// ---------------------------------------------------------------------------
module tb_serial_link;

    localparam int CLK_DIV  = 512;
    localparam int FAST_DIV = CLK_DIV / 32;

    logic clock = 1'b0;
    logic reset;
    logic int_req;
    logic int_ack;
    logic sclk_in;
    logic sclk_out;
    logic sclk_oe;
    logic sin;
    logic sout;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rd_exp_q[$];
    string      rd_name_q[$];
    logic       sout_exp_q[$];
    logic       mon_prev_sclk = 1'b1;

    logic [7:0] r_tx;
    logic [7:0] r_rx;

    serial_link_if bus ();

    serial_link #(.CLK_DIV(CLK_DIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .int_req  (int_req),
        .int_ack  (int_ack),
        .sclk_in  (sclk_in),
        .sclk_out (sclk_out),
        .sclk_oe  (sclk_oe),
        .sin      (sin),
        .sout     (sout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    // SC read model: mode = {fast, clk_sel}. Without the fast option bit1
    // always reads 1.
    function automatic logic [7:0] sc_model(input logic start, input logic [1:0] mode);
`ifdef SERIAL_FAST_CLOCK_EN
        return {start, 5'b11111, mode[1], mode[0]};
`else
        return {start, 5'b11111, mode[1] | 1'b1, mode[0]};
`endif
    endfunction

    task automatic monitor_read();
        logic [7:0] exp_val;
        string      exp_name;
        check("read_queue_nonempty", 32'(rd_exp_q.size() != 0), 32'd1);
        if (rd_exp_q.size() != 0) begin
            exp_val  = rd_exp_q.pop_front();
            exp_name = rd_name_q.pop_front();
            check(exp_name, bus.Do, exp_val);
        end
    endtask

    task automatic monitor_sout();
        logic exp_bit;
        check("sout_queue_nonempty", 32'(sout_exp_q.size() != 0), 32'd1);
        if (sout_exp_q.size() != 0) begin
            exp_bit = sout_exp_q.pop_front();
            check("sout_bit_at_sclk_rise", sout, exp_bit);
        end
    endtask

    // Read scoreboard: any active read strobe must match the next queued value.
    always @(negedge clock) begin
        if (bus.rd_n === 1'b0) begin
            monitor_read();
        end
    end

    // sout scoreboard: sample the data bit on every driven sclk_out rise.
    always @(negedge clock) begin
        if (sclk_oe && sclk_out && !mon_prev_sclk) begin
            monitor_sout();
        end
        mon_prev_sclk <= sclk_out;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
        bus.cs   = 1'b1;
        bus.wr_n = 1'b0;
        bus.A    = addr;
        bus.Di   = data;
        @(posedge clock);
        #1;
        bus.cs   = 1'b0;
        bus.wr_n = 1'b1;
    endtask

    task automatic read_expect(input logic [15:0] addr, input logic [7:0] exp_val,
                               input string name, input logic use_cs);
        rd_exp_q.push_back(exp_val);
        rd_name_q.push_back(name);
        bus.cs   = use_cs;
        bus.rd_n = 1'b0;
        bus.A    = addr;
        @(posedge clock);
        #1;
        bus.cs   = 1'b0;
        bus.rd_n = 1'b1;
    endtask

    task automatic applyStimulus_internal(input logic [7:0] tx, input logic [7:0] rx,
                                          input logic [7:0] sc, input int period);
        int   n     = 0;
        int   rises = 0;
        logic prev;
        write_reg(16'hFF01, tx);
        sin = rx[7];
        for (int i = 7; i >= 0; i--) sout_exp_q.push_back(tx[i]);
        write_reg(16'hFF02, sc);
        prev = sclk_out;
        while (int_req !== 1'b1 && n < 8 * period + 64) begin
            tick(1);
            n++;
            if (!prev && sclk_out) rises++;
            if (prev && !sclk_out && rises > 0 && rises < 8) sin = rx[7 - rises];
            prev = sclk_out;
        end
        check_range("int_req_latency", n, 8 * period - 1, 8 * period + 1);
        check("internal_sclk_rises", rises, 8);
        read_expect(16'hFF01, rx, "sb_after_internal", 1'b1);
        read_expect(16'hFF02, sc_model(1'b0, sc[1:0]), "sc_after_internal", 1'b1);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("int_req_cleared_by_ack", int_req, 1'b0);
    endtask

    task automatic applyStimulus_external(input logic [7:0] tx, input logic [7:0] rx,
                                          input int half, input logic ack_at_completion);
        write_reg(16'hFF01, tx);
        write_reg(16'hFF02, 8'h80);
        for (int i = 7; i >= 0; i--) begin
            sclk_in = 1'b0;
            sin     = rx[i];
            tick(half);
            check("ext_sout_bit", sout, tx[i]);
            if (i == 6) read_expect(16'hFF02, sc_model(1'b1, 2'b00), "sc_during_external", 1'b1);
            if (i == 4) write_reg(16'hFF01, ~rx);
            sclk_in = 1'b1;
            if (i > 0) tick(half);
        end
        int_ack = ack_at_completion;
        tick(2);
        check("ext_int_req_before_latency", int_req, 1'b0);
        tick(1);
        int_ack = 1'b0;
        check("ext_int_req_after_latency", int_req, 1'b1);
        read_expect(16'hFF01, rx, "sb_after_external", 1'b1);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("ext_int_req_cleared", int_req, 1'b0);
        sclk_in = 1'b0;
        sin     = ~sin;
        tick(half);
        sclk_in = 1'b1;
        tick(half + 3);
        check("ninth_pulse_int_req", int_req, 1'b0);
        check("ninth_pulse_sout", sout, 1'b1);
        read_expect(16'hFF01, rx, "sb_after_ninth_pulse", 1'b1);
        read_expect(16'hFF02, sc_model(1'b0, 2'b00), "sc_after_ninth_pulse", 1'b1);
    endtask

    task automatic applyStimulus_abort(input logic [7:0] tx);
        int         n     = 0;
        int         rises = 0;
        logic       prev;
        logic [7:0] partial;
        partial = tx << 3;
        write_reg(16'hFF01, tx);
        sin = 1'b0;
        for (int i = 7; i >= 5; i--) sout_exp_q.push_back(tx[i]);
        write_reg(16'hFF02, 8'h81);
        prev = sclk_out;
        while (rises < 3 && n < 4 * CLK_DIV) begin
            tick(1);
            n++;
            if (!prev && sclk_out) rises++;
            prev = sclk_out;
        end
        check("abort_rises_seen", rises, 3);
        tick(8);
        write_reg(16'hFF02, 8'h01);
        check("abort_sout_idle", sout, 1'b1);
        read_expect(16'hFF02, sc_model(1'b0, 2'b01), "sc_after_abort", 1'b1);
        read_expect(16'hFF01, partial, "sb_partial_after_abort", 1'b1);
        tick(CLK_DIV + 64);
        check("abort_no_int_req", int_req, 1'b0);
    endtask

    task automatic checkOutput_reset();
        check("reset_int_req", int_req, 1'b0);
        check("reset_sout", sout, 1'b1);
        check("reset_sclk_out", sclk_out, 1'b1);
        check("reset_sclk_oe", sclk_oe, 1'b0);
        read_expect(16'hFF02, sc_model(1'b0, 2'b00), "reset_sc", 1'b1);
        read_expect(16'hFF01, 8'h00, "reset_sb", 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        bus.cs   = 1'b0;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.A    = 16'h0000;
        bus.Di   = 8'h00;
        int_ack  = 1'b0;
        sclk_in  = 1'b1;
        sin      = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);

        checkOutput_reset();
        read_expect(16'hFF00, 8'hFF, "read_unmapped_addr", 1'b1);
        read_expect(16'hFF01, 8'hFF, "read_without_cs", 1'b0);

        applyStimulus_internal(8'hA5, 8'h00, 8'h81, CLK_DIV);
        applyStimulus_external(8'h00, 8'hFF, 6, 1'b0);
        applyStimulus_external(8'($urandom), 8'($urandom), 5, 1'b1);
        applyStimulus_abort(8'hC3);

        for (int k = 0; k < 3; k++) begin
            r_tx = 8'($urandom);
            r_rx = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus_internal(r_tx, r_rx, 8'h81, CLK_DIV);
            end else begin
                applyStimulus_external(r_tx, r_rx, $urandom_range(4, 9), 1'b0);
            end
        end

`ifdef SERIAL_FAST_CLOCK_EN
        applyStimulus_internal(8'($urandom), 8'($urandom), 8'h83, FAST_DIV);
`endif

        // Reset in the middle of an internal transfer (sclk_out low, sout=0).
        write_reg(16'hFF01, 8'h3C);
        write_reg(16'hFF02, 8'h81);
        tick(100);
        reset = 1'b1;
        #1;
        check("midreset_sclk_out", sclk_out, 1'b1);
        check("midreset_sout", sout, 1'b1);
        check("midreset_sclk_oe", sclk_oe, 1'b0);
        check("midreset_int_req", int_req, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);
        checkOutput_reset();

        tick(2);
        check("sout_queue_drained", sout_exp_q.size(), 0);
        check("read_queue_drained", rd_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog_timeout actual=expired required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
